// File: rtl/direction_pkg.sv
// Shared types, segment codes and counter-width helper for the direction indicator.
package direction_pkg;

   typedef enum logic [1:0] {DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic [1:0] {ST_BLANK, ST_ACTIVE, ST_STALE} state_t;

   // Active-low {g..a}
   localparam logic [6:0] SEG_F    = 7'b0001110;
   localparam logic [6:0] SEG_B    = 7'b0000011;
   localparam logic [6:0] SEG_L    = 7'b1000111;
   localparam logic [6:0] SEG_R    = 7'b0101111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [6:0] seg_letter(input dir_t d);
      logic [6:0] s;
      s = SEG_OFF;
      case (d)
         DIR_FWD:   s = SEG_F;
         DIR_REV:   s = SEG_B;
         DIR_LEFT:  s = SEG_L;
         DIR_RIGHT: s = SEG_R;
         default:   s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/direction_indicator_tick_gen.sv
// Free-running prescaler: one-cycle tick each time the count wraps; held at 0 while disabled.
module tick_gen
   import direction_pkg::*;
#(
   parameter int TICK_DIV = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            W    = cnt_w(TICK_DIV);
   localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en || cnt_q == LAST) cnt_d = '0;
      else                      cnt_d = cnt_q + W'(1);
   end

   assign tick = en && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/direction_indicator.sv
// Latches a strobed direction and drives four 7-seg digits with blink, hazard and stale timeout.
module direction_indicator
   import direction_pkg::*;
#(
   parameter int         TICK_DIV      = 50_000,
   parameter int         BLINK_TICKS   = 250,
   parameter int         TIMEOUT_TICKS = 2000,
   parameter logic [3:0] BLINK_MASK    = 4'b1100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       dir_valid,
   input  logic [1:0] direc,
   input  logic       hazard,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3
);

   localparam int            BW         = cnt_w(BLINK_TICKS);
   localparam int            TW         = cnt_w(TIMEOUT_TICKS);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1);

   state_t        state_q, state_d;
   dir_t          dir_q, dir_d;
   logic          phase_q, phase_d;
   logic [BW-1:0] blink_q, blink_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tick;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      phase_d = phase_q;
      blink_d = blink_q;
      tmo_d   = tmo_q;
      if (!enable) begin
         state_d = ST_BLANK;
         phase_d = 1'b1;
         blink_d = '0;
         tmo_d   = '0;
      end else if (dir_valid) begin
         // A coincident tick is dropped: the strobe restarts the timeout anyway.
         state_d = ST_ACTIVE;
         dir_d   = dir_t'(direc);
         tmo_d   = '0;
         if (dir_t'(direc) != dir_q || state_q != ST_ACTIVE) begin
            blink_d = '0;
            phase_d = 1'b1;
         end
      end else if (state_q == ST_ACTIVE && tick) begin
         if (TIMEOUT_TICKS != 0 && tmo_q == TO_LAST) begin
            state_d = ST_STALE;
         end else begin
            if (TIMEOUT_TICKS != 0) tmo_d = tmo_q + TW'(1);
            if (blink_q == BLINK_LAST) begin
               blink_d = '0;
               phase_d = ~phase_q;
            end else begin
               blink_d = blink_q + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         dir_q   <= DIR_FWD;
         phase_q <= 1'b1;
         blink_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
         tmo_q   <= tmo_d;
      end
   end

   // Segment pattern per direction; mapped onto physical digits below.
   logic [3:0][6:0] seg_dir;

   always_comb begin
      seg_dir = {4{SEG_OFF}};
      for (int d = 0; d < 4; d++) begin
         case (state_q)
            ST_ACTIVE: begin
               if (hazard) begin
                  if (phase_q) seg_dir[d] = seg_letter(dir_t'(d[1:0]));
               end else if (dir_q == dir_t'(d[1:0]) && (phase_q || !BLINK_MASK[dir_q])) begin
                  seg_dir[d] = seg_letter(dir_t'(d[1:0]));
               end
            end
            ST_STALE: seg_dir[d] = SEG_DASH;
            default:  seg_dir[d] = SEG_OFF;
         endcase
      end
   end

   assign HEX0 = seg_dir[DIR_RIGHT];
   assign HEX1 = seg_dir[DIR_LEFT];
   assign HEX2 = seg_dir[DIR_FWD];
   assign HEX3 = seg_dir[DIR_REV];

endmodule

// File: tb/tb_direction_indicator.sv
// Directed bench for direction_indicator with a tick-counting reference model checked every cycle.
module tb_direction_indicator;

   localparam int TB_TD = 4;
   localparam int TB_BT = 2;
   localparam int TB_TO = 5;

   localparam logic [6:0] S_F = 7'b0001110;
   localparam logic [6:0] S_B = 7'b0000011;
   localparam logic [6:0] S_L = 7'b1000111;
   localparam logic [6:0] S_R = 7'b0101111;
   localparam logic [6:0] S_D = 7'b0111111;
   localparam logic [6:0] S_O = 7'h7F;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       dir_valid;
   logic [1:0] direc;
   logic       hazard;
   logic [6:0] HEX0, HEX1, HEX2, HEX3;
   logic [27:0] hex_all;

   int  n_cmp = 0;
   int  n_err = 0;
   bit  done  = 0;

   // Physical digit index and letter, both indexed by direction code.
   int         POS [4] = '{2, 3, 1, 0};
   logic [6:0] LET [4] = '{7'b0001110, 7'b0000011, 7'b1000111, 7'b0101111};
   logic [3:0] mask    = 4'b1100;

   direction_indicator #(
      .TICK_DIV      (TB_TD),
      .BLINK_TICKS   (TB_BT),
      .TIMEOUT_TICKS (TB_TO),
      .BLINK_MASK    (4'b1100)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .dir_valid (dir_valid),
      .direc     (direc),
      .hazard    (hazard),
      .HEX0      (HEX0),
      .HEX1      (HEX1),
      .HEX2      (HEX2),
      .HEX3      (HEX3)
   );

   assign hex_all = {HEX3, HEX2, HEX1, HEX0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: state, enabled-cycle count, ticks since phase restart, idle ticks.
   int m_st   = 0;  // 0 blank, 1 active, 2 stale
   int m_dir  = 0;
   int m_cyc  = 0;
   int m_bt   = 0;
   int m_idle = 0;

   always @(posedge clk or negedge rst_n) begin
      bit tk;
      if (!rst_n) begin
         m_st = 0; m_dir = 0; m_cyc = 0; m_bt = 0; m_idle = 0;
      end else if (!enable) begin
         m_st = 0; m_cyc = 0; m_bt = 0; m_idle = 0;
      end else begin
         tk = (m_cyc % TB_TD) == TB_TD - 1;
         m_cyc++;
         if (dir_valid) begin
            if (m_st != 1 || int'(direc) != m_dir) m_bt = 0;
            m_st   = 1;
            m_dir  = int'(direc);
            m_idle = 0;
         end else if (m_st == 1 && tk) begin
            if (m_idle + 1 == TB_TO) m_st = 2;
            else begin
               m_idle++;
               m_bt++;
            end
         end
      end
   end

   function automatic logic [27:0] model_out();
      logic [27:0] r  = {4{S_O}};
      bit          ph = ((m_bt / TB_BT) % 2) == 0;
      if (m_st == 2) r = {4{S_D}};
      else if (m_st == 1)
         for (int d = 0; d < 4; d++)
            if ((hazard && ph) || (!hazard && d == m_dir && (ph || !mask[d])))
               r[POS[d]*7 +: 7] = LET[d];
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (!done) check("model", hex_all, model_out());
      end
   end

   // Hand-derived expectation after edge e (edges counted from reset release; ticks on multiples of 4).
   function automatic logic [27:0] lit_exp(input int e);
      bit lit = (e < 32) || (e >= 40 && e < 48) || (e >= 56 && e < 64);
      if (e <= 3 || (e >= 74 && e <= 78) || e >= 81) return {S_O, S_O, S_O, S_O};
      if (e <= 23) return {S_O, S_F, S_O, S_O};
      if (e == 24 || e == 68) return {S_D, S_D, S_D, S_D};
      if (e == 25 || (e >= 69 && e <= 73)) return {S_O, S_O, S_O, S_R};
      if (e >= 79) return {S_O, S_O, S_L, S_O};
      if (e >= 48) return lit ? {S_B, S_F, S_L, S_R} : {S_O, S_O, S_O, S_O};
      return lit ? {S_O, S_O, S_L, S_O} : {S_O, S_O, S_O, S_O};
   endfunction

   initial begin
      rst_n = 1'b0; enable = 1'b1; dir_valid = 1'b0; direc = 2'd0; hazard = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", hex_all, {4{S_O}});
      rst_n = 1'b1;
      for (int e = 1; e <= 85; e++) begin
         @(negedge clk);
         check($sformatf("edge%0d", e), hex_all, lit_exp(e));
         case (e)
            3:  begin dir_valid = 1'b1; direc = 2'd0; end
            4:  dir_valid = 1'b0;
            24: begin dir_valid = 1'b1; direc = 2'd3; end
            25: direc = 2'd2;
            26: dir_valid = 1'b0;
            33: dir_valid = 1'b1;
            34: dir_valid = 1'b0;
            47: hazard = 1'b1;
            49: dir_valid = 1'b1;
            50: dir_valid = 1'b0;
            68: begin dir_valid = 1'b1; direc = 2'd3; hazard = 1'b0; end
            69: dir_valid = 1'b0;
            73: enable = 1'b0;
            74: hazard = 1'b1;
            76: enable = 1'b1;
            78: begin hazard = 1'b0; dir_valid = 1'b1; direc = 2'd2; end
            79: dir_valid = 1'b0;
            80: begin
               #1 rst_n = 1'b0;
               #1 check("async_rst", hex_all, {4{S_O}});
               #1 rst_n = 1'b1;
            end
            82: hazard = 1'b1;
            default: ;
         endcase
      end
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
